// File: rtl/sar_pkg.sv
// Shared SAR definitions: default resolution, result-word type and the averager FSM states.
package sar_pkg;

    localparam int SAR_BITS = 9;

    typedef logic [SAR_BITS:0] sar_word_t;

    typedef enum logic {
        ST_DISCARD = 1'b0,
        ST_ACCUM   = 1'b1
    } sar_state_t;

endpackage

// File: rtl/sar_avg_accum.sv
// Window accumulator: sums 2^LOG2_AVG SAR results and emits the rounded mean with a done pulse.
module sar_avg_accum
    import sar_pkg::*;
#(
    parameter int BITS     = SAR_BITS,
    parameter int LOG2_AVG = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            add_i,
    input  logic [BITS:0]   result_i,
    output logic [BITS:0]   avg_o,
    output logic            done_o
);

    localparam int W  = BITS + 1 + LOG2_AVG;
    localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
    // Half an LSB of the output; evaluates to zero when no averaging is configured.
    localparam logic [W-1:0]  RND      = W'((1 << LOG2_AVG) >> 1);

    logic [W-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  total;

    always_comb begin
        total  = sum_q + W'(result_i) + RND;
        avg_o  = (BITS+1)'(total >> LOG2_AVG);
        done_o = add_i && (cnt_q == CNT_LAST);
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        if (clear_i || done_o) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + W'(result_i);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sar_result_averager.sv
// SAR result averager: edge-detects the sample strobe, discards the first stale capture,
// averages fixed windows and hands results downstream. SAR_AVG_OVERRUN_CNT_EN adds overrun_cnt.
module sar_result_averager
    import sar_pkg::*;
#(
    parameter int BITS     = SAR_BITS,
    parameter int LOG2_AVG = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clk_sample,
    input  logic [BITS:0] result,
    input  logic          clear,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [BITS:0] out_data,
    output logic          overrun,
`ifdef SAR_AVG_OVERRUN_CNT_EN
    output logic [7:0]    overrun_cnt,
`endif
    output logic          dbg_state_o
);

    sar_state_t    state_q, state_d;
    logic          sample_q;
    logic          capture;
    logic          add;
    logic          done;
    logic [BITS:0] avg;
    logic          xfer;
    logic          valid_q, valid_d;
    logic [BITS:0] data_q, data_d;
    logic          ovr_q, ovr_d;
    logic          drop;

    sar_avg_accum #(
        .BITS     (BITS),
        .LOG2_AVG (LOG2_AVG)
    ) u_accum (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (clear),
        .add_i    (add),
        .result_i (result),
        .avg_o    (avg),
        .done_o   (done)
    );

    // Handshake: a word moves on any cycle with out_valid && out_ready; out_data is held
    // while out_valid is high, and an average finished while the word is stuck is dropped.
    always_comb begin
        capture = clk_sample && !sample_q;
        add     = capture && !clear && (state_q == ST_ACCUM);
        xfer    = valid_q && out_ready;
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        drop    = 1'b0;
        if (clear) begin
            state_d = ST_DISCARD;
        end else if (capture && (state_q == ST_DISCARD)) begin
            state_d = ST_ACCUM;
        end
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (done) begin
            if (!valid_q || out_ready) begin
                data_d  = avg;
                valid_d = 1'b1;
            end else begin
                drop  = 1'b1;
                ovr_d = 1'b1;
            end
        end
        if (clear) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_DISCARD;
            sample_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= clk_sample;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef SAR_AVG_OVERRUN_CNT_EN
    logic [7:0] ocnt_q, ocnt_d;

    always_comb begin
        ocnt_d = ocnt_q;
        if (clear) begin
            ocnt_d = '0;
        end else if (drop && (ocnt_q != 8'hFF)) begin
            ocnt_d = ocnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end

    assign overrun_cnt = ocnt_q;
`endif

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign overrun     = ovr_q;
    assign dbg_state_o = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_sar_result_averager.sv
// Bench for sar_result_averager: default 4-sample instance plus a LOG2_AVG=0 instance.
module tb_sar_result_averager;

    logic       clock;
    logic       reset;
    logic       clk_sample;
    logic [9:0] result;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       overrun;
    logic       dbg_state;

    logic       b_sample;
    logic [9:0] b_result;
    logic       b_clear;
    logic       b_ready;
    logic       b_valid;
    logic [9:0] b_data;
    logic       b_overrun;
    logic       b_dbg_state;

`ifdef SAR_AVG_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
    logic [7:0] b_overrun_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp0_q[$];

    sar_result_averager #(.BITS(9), .LOG2_AVG(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .clk_sample  (clk_sample),
        .result      (result),
        .clear       (clear),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .overrun     (overrun),
`ifdef SAR_AVG_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    sar_result_averager #(.BITS(9), .LOG2_AVG(0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .clk_sample  (b_sample),
        .result      (b_result),
        .clear       (b_clear),
        .out_ready   (b_ready),
        .out_valid   (b_valid),
        .out_data    (b_data),
        .overrun     (b_overrun),
`ifdef SAR_AVG_OVERRUN_CNT_EN
        .overrun_cnt (b_overrun_cnt),
`endif
        .dbg_state_o (b_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared with the oldest expected average.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 1);
            else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (!reset && b_valid && b_ready) begin
            if (exp0_q.size() == 0) check("spurious_out0", 32'(exp0_q.size()), 1);
            else check("out_data0", 32'(b_data), 32'(exp0_q.pop_front()));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic capture(input logic [9:0] v);
        clk_sample = 1'b1;
        result     = v;
        cycles(1);
        clk_sample = 1'b0;
        result     = 10'($urandom_range(0, 1023));
        cycles(1);
    endtask

    task automatic send_window(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                               input logic [9:0] d, input bit push);
        logic [11:0] s;
        s = 12'(a) + 12'(b) + 12'(c) + 12'(d) + 12'd2;
        if (push) exp_q.push_back(10'(s >> 2));
        capture(a);
        capture(b);
        capture(c);
        clk_sample = 1'b1;
        result     = d;
        cycles(1);
        check("latency_valid", 32'(out_valid), 1);
        clk_sample = 1'b0;
        cycles(1);
    endtask

    task automatic capture_b(input logic [9:0] v, input bit expect_out);
        if (expect_out) exp0_q.push_back(v);
        b_sample = 1'b1;
        b_result = v;
        cycles(1);
        if (expect_out) check("latency_valid0", 32'(b_valid), 1);
        b_sample = 1'b0;
        cycles(1);
    endtask

    initial begin
        logic [9:0] r0, r1, r2, r3;
        reset = 1'b1; clk_sample = 1'b0; result = '0; clear = 1'b0; out_ready = 1'b1;
        b_sample = 1'b0; b_result = '0; b_clear = 1'b0; b_ready = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Basic window, corner values and rounding
        capture(10'd500);
        check("state_accum", 32'(dbg_state), 1);
        send_window(10'd100, 10'd101, 10'd102, 10'd103, 1'b1);
        check("valid_falls", 32'(out_valid), 0);
        send_window(10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        send_window(10'd1, 10'd1, 10'd1, 10'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            r0 = 10'($urandom_range(0, 1023)); r1 = 10'($urandom_range(0, 1023));
            r2 = 10'($urandom_range(0, 1023)); r3 = 10'($urandom_range(0, 1023));
            send_window(r0, r1, r2, r3, 1'b1);
        end

        // Back-pressure across two windows: the second is dropped
        out_ready = 1'b0;
        send_window(10'd10, 10'd10, 10'd10, 10'd10, 1'b1);
        send_window(10'd20, 10'd20, 10'd20, 10'd20, 1'b0);
        check("ovr_data_held", 32'(out_data), 10);
        check("ovr_flag", 32'(overrun), 1);
`ifdef SAR_AVG_OVERRUN_CNT_EN
        check("ovr_cnt", 32'(overrun_cnt), 1);
`endif
        out_ready = 1'b1;
        cycles(2);
        check("ovr_drained", 32'(out_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Clear mid-window with a pending word and a simultaneous capture
        out_ready = 1'b0;
        send_window(10'd30, 10'd30, 10'd30, 10'd30, 1'b1);
        capture(10'd50);
        capture(10'd60);
        clear = 1'b1; clk_sample = 1'b1; result = 10'd777;
        cycles(1);
        clear = 1'b0; clk_sample = 1'b0;
        cycles(1);
        check("clr_valid_kept", 32'(out_valid), 1);
        check("clr_data_kept", 32'(out_data), 30);
        check("clr_overrun", 32'(overrun), 0);
        check("clr_state", 32'(dbg_state), 0);
`ifdef SAR_AVG_OVERRUN_CNT_EN
        check("clr_ovr_cnt", 32'(overrun_cnt), 0);
`endif
        out_ready = 1'b1;
        cycles(2);
        capture(10'd999);
        send_window(10'd200, 10'd201, 10'd202, 10'd203, 1'b1);

        // Reset mid-window with a word pending
        out_ready = 1'b0;
        send_window(10'd40, 10'd40, 10'd40, 10'd40, 1'b0);
        check("pre_rst_data", 32'(out_data), 40);
        capture(10'd5);
        capture(10'd5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_state", 32'(dbg_state), 0);
        out_ready = 1'b1;
        capture(10'd9);
        send_window(10'd60, 10'd61, 10'd62, 10'd63, 1'b1);

        // Pass-through instance
        capture_b(10'd7, 1'b0);
        check("b_no_out_discard", 32'(b_valid), 0);
        capture_b(10'd300, 1'b1);
        capture_b(10'd1023, 1'b1);
        capture_b(10'd0, 1'b1);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp0_q.size() != 0); i++) cycles(1);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("queue0_empty", 32'(exp0_q.size()), 0);
        check("final_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sar_result_averager.md
SAR_RESULT_AVERAGER -- requirements
Module: sar_result_averager

Interface
REQ-001 Parameter BITS, default 9; SAR resolution, so the input result word is BITS+1 bits wide.
REQ-002 Parameter LOG2_AVG, default 2; each window averages 2^LOG2_AVG conversions; legal range 0..4.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clk_sample  input  1  SAR sample strobe, registered in the SAR clock domain (same clock).
REQ-006 result  input  BITS+1  SAR conversion word; valid in every cycle where clk_sample is 1.
REQ-007 clear  input  1  synchronous window restart and overrun clear.
REQ-008 out_ready  input  1  downstream accepts out_data.
REQ-009 out_valid  output  1  out_data holds an unconsumed average.
REQ-010 out_data  output  BITS+1  rounded window average.
REQ-011 overrun  output  1  sticky flag: a completed window was dropped.

Function
REQ-012 Capture event = clk_sample high in this cycle while the registered previous clk_sample is low (rising-edge detect); result is sampled in that same cycle.
REQ-013 FSM states: ST_DISCARD and ST_ACCUM.
- ST_DISCARD: the first capture after reset or clear is dropped (it carries stale SAR bits), then the FSM goes to ST_ACCUM.
- ST_ACCUM: never leaves except via reset or clear.
REQ-014 In ST_ACCUM, each capture adds result into the accumulator (width BITS+1+LOG2_AVG, no overflow possible) and increments a LOG2_AVG-bit sample counter.
REQ-015 On the capture that completes a window, the block computes avg = (sum + result + 2^(LOG2_AVG-1)) >> LOG2_AVG (no rounding term when LOG2_AVG=0), then clears the accumulator and counter in the same cycle.
REQ-016 Result fits BITS+1 bits by construction (max 2^(BITS+1)-1); no saturation logic.
REQ-017 Latency: out_valid rises on the clock edge following the window-completing capture cycle (1 cycle).
REQ-018 Output handshake: a transfer occurs on a cycle where out_valid and out_ready are both 1; out_valid falls after a transfer unless a new average loads in the same cycle.
REQ-019 While out_valid is 1, out_data stays stable until transferred.
REQ-020 New average with out_valid=0, or with a transfer in the same cycle: load out_data and keep/raise out_valid.
REQ-021 New average with out_valid=1 and out_ready=0: drop the new average, keep out_data, set overrun.
REQ-022 clear: the accumulator, counter and overrun go to 0 and the FSM goes to ST_DISCARD. out_valid and out_data are unaffected; the pending word remains transferable.
REQ-023 clear takes priority over a capture in the same cycle; that capture is ignored.
REQ-024 LOG2_AVG=0: every capture after the discard produces out_data = result.

Reset
REQ-025 reset takes priority over all inputs and forces:
- FSM to ST_DISCARD;
- accumulator, counter, registered clk_sample, out_data and overrun to 0;
- out_valid to 0.
REQ-026 Reset asserted mid-window discards the partial sum; no output is generated for it.

Configuration
REQ-027 Macro SAR_AVG_OVERRUN_CNT_EN defined: adds output overrun_cnt (8 bits), a saturating count of dropped windows, held at 255 once reached, zeroed by reset or clear.
REQ-028 Macro SAR_AVG_OVERRUN_CNT_EN undefined: no overrun_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-029 Shared package sar_pkg holds the BITS default, the result-word type and the FSM state enum (ST_DISCARD, ST_ACCUM), for reuse by the SAR logic and downstream blocks.
REQ-030 One sub-module, sar_avg_accum: the accumulator, sample counter and rounding, producing the average value and a done pulse. The top level keeps the edge detect, FSM, output register and handshake.

Verification
REQ-031 Defaults (BITS=9, LOG2_AVG=2), out_ready=1: captures 500 (discarded), 100, 101, 102, 103 -> one out_valid pulse, out_data=102.
REQ-032 Captures of 1023 x4 after the discard -> out_data=1023; also captures 1,1,1,2 -> out_data=1 (sum 5 + 2 = 7, >>2 = 1).
REQ-033 out_ready=0 across two full windows (averages 10, then 20):
- out_data stays 10 and overrun=1 (overrun_cnt=1 when the macro is enabled);
- out_ready=1 -> 10 transfers, then out_valid=0.
REQ-034 clear asserted after 2 captures of a window:
- the partial sum is lost and overrun goes to 0;
- the next capture is discarded;
- the next 4 captures produce their own average.
REQ-035 Reset asserted for 1 cycle mid-window with out_valid=1 -> all outputs 0 the next cycle; the first post-reset capture is discarded.
REQ-036 LOG2_AVG=0: captures 7, 300, 1023 after the discard -> out_data 300, then 1023, each 1 cycle after its capture.
